// File: rtl/isa_encoder_loader_if.sv
// Request handshake and instruction-memory write bus for isa_encoder_loader.
// master: the bench/boot sequencer side; slave: the loader.
interface isa_encoder_loader_if #(
  parameter int ADDR_W = 4
);
  logic              req_valid;
  logic              req_ready;
  logic              req_add;
  logic              req_li;
  logic              req_bne;
  logic [1:0]        req_a;
  logic [1:0]        req_b;
  logic [1:0]        req_c;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [7:0]        imem_wdata;

  modport master (
    output req_valid, req_add, req_li, req_bne, req_a, req_b, req_c,
    input  req_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  req_valid, req_add, req_li, req_bne, req_a, req_b, req_c,
    output req_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/isa_encoder_loader.sv
// Program loader for the sCPU instruction memory: encodes one-hot typed
// requests into 8-bit sISA words, writes them from address 0 upward and pads
// the remainder with the empty instruction (8'h40) on finish.
// Optional feature macro: ENC_ONEHOT_CHECK_EN (strict one-hot type check with
// a sticky err flag); when undefined the type is priority encoded and err = 0.
module isa_encoder_loader #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 finish,
  isa_encoder_loader_if.slave  bus,
  output logic [ADDR_W:0]      inst_count,
  output logic                 done,
  output logic                 err
);

  typedef enum logic [1:0] {IDLE, LOAD, PAD, DONE} state_t;

  localparam logic [7:0]    EMPTY_WORD = 8'h40;
  localparam logic [ADDR_W:0] LAST_ADDR = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] FULL_ADDR = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE       = (ADDR_W+1)'(1);

  state_t            state_q, state_d;
  logic [ADDR_W:0]   addr_q, addr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              err_q, err_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [7:0]        wdata_q, wdata_d;

  logic [1:0]        op;
  logic              type_ok;
  logic [7:0]        enc_word;
  logic              handshake;

  // Opcode selection from the request type flags.
  always_comb begin
    // NOTE: every signal written in a combinational block gets a default
    // first, so no path leaves it unassigned and no latch is inferred.
    op      = 2'b01;
    type_ok = 1'b1;
`ifdef ENC_ONEHOT_CHECK_EN
    case ({bus.req_add, bus.req_li, bus.req_bne})
      3'b100:  op = 2'b00;
      3'b010:  op = 2'b10;
      3'b001:  op = 2'b11;
      default: type_ok = 1'b0;
    endcase
`else
    if (bus.req_add)      op = 2'b00;
    else if (bus.req_li)  op = 2'b10;
    else if (bus.req_bne) op = 2'b11;
`endif
  end

  // Illegal or missing type encodes as the empty word; operands only otherwise.
  assign enc_word  = (!type_ok || op == 2'b01) ? EMPTY_WORD
                                               : {op, bus.req_a, bus.req_b, bus.req_c};
  assign handshake = bus.req_valid && (state_q == LOAD);

  // Next-state and next-datapath logic for the load FSM.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    count_d = count_q;
    err_d   = err_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = LOAD;
          addr_d  = '0;
          count_d = '0;
          err_d   = 1'b0;
        end
      end
      LOAD: begin
        if (handshake) begin
          we_d    = 1'b1;
          waddr_d = addr_q[ADDR_W-1:0];
          wdata_d = enc_word;
          addr_d  = addr_q + ONE;
          count_d = count_q + ONE;
          if (!type_ok) err_d = 1'b1;
        end
        if (handshake && addr_q == LAST_ADDR) state_d = DONE;
        else if (finish)                      state_d = (addr_d == FULL_ADDR) ? DONE : PAD;
      end
      PAD: begin
        we_d    = 1'b1;
        waddr_d = addr_q[ADDR_W-1:0];
        wdata_d = EMPTY_WORD;
        addr_d  = addr_q + ONE;
        if (addr_q == LAST_ADDR) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered write port; reset squashes any pending write.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      err_q   <= err_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  assign bus.req_ready  = (state_q == LOAD);
  assign bus.imem_we    = we_q;
  assign bus.imem_addr  = waddr_q;
  assign bus.imem_wdata = wdata_q;
  assign inst_count     = count_q;
  assign done           = (state_q == DONE);
  assign err            = err_q;

endmodule

// File: doc/isa_encoder_loader.md
# isa_encoder_loader

Program loader for the sCPU instruction memory. It accepts instruction requests one at a time, each carrying a one-hot type flag (`add`, `li`, `bne`) and three operand fields. It encodes each request into an 8-bit sISA word and writes the words to consecutive instruction-memory addresses from 0. On `finish` it fills the remaining addresses with the empty instruction. It sits between the bench/boot sequencer and the instruction memory, and is the encoding counterpart of the core's opcode-type decode.

## Interface
- `DEPTH`, 16: instruction memory words; power of two, 2..256
- `ADDR_W`, 4: `log2(DEPTH)`
- `clk`  in  1  single clock, all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  begin a load session
- `finish`  in  1  end the session and pad the rest of memory
- `req_valid`  in  1  request present
- `req_ready`  out  1  request accepted when `req_valid & req_ready`
- `req_add`, `req_li`, `req_bne`  in  1 each  one-hot instruction type
- `req_a`, `req_b`, `req_c`  in  2 each  operand fields
- `imem_we`  out  1  write strobe
- `imem_addr`  out  ADDR_W  write address
- `imem_wdata`  out  8  encoded word
- `inst_count`  out  ADDR_W+1  number of non-padding words written this session
- `done`  out  1  session complete, memory fully written
- `err`  out  1  sticky illegal-type flag

## Operation
- Word format: `op[7:6]`, `a[5:4]`, `b[3:2]`, `c[1:0]`.
  - add: op 00; a = rd, b = rs1, c = rs2.
  - li: op 10; a = rd; {b,c} = imm4.
  - bne: op 11; a = rs; {b,c} = signed offset4.
  - empty: op 01, all other bits 0, so the word is 8'h40.
- Encoding always places `req_a`/`req_b`/`req_c` into bits 5:4 / 3:2 / 1:0. Only `op` depends on type.
- FSM states: IDLE, LOAD, PAD, DONE.
- IDLE/DONE: `start` leads to LOAD and sets `addr` := 0, `inst_count` := 0, `err` := 0.
- LOAD: `req_ready` = 1.
  - On handshake, write `addr` and increment it.
  - If the written address is DEPTH-1, go to DONE.
  - Otherwise, `finish` goes to PAD, or to DONE if `addr` = DEPTH.
- PAD: each cycle writes 8'h40 to `addr` and increments it. After writing DEPTH-1, go to DONE.
- `start` is ignored in LOAD and PAD. `finish` is ignored outside LOAD.
- `req_ready` = 0 in IDLE, PAD and DONE.
- Internal `addr` is ADDR_W+1 bits wide; `imem_addr` is its low ADDR_W bits.
- `inst_count` increments per accepted request. It saturates only by construction, with a maximum of DEPTH.
- `done` = (state == DONE).

## Timing
- Reset values: state IDLE; `req_ready` 0, `imem_we` 0, `imem_addr` 0, `imem_wdata` 0, `inst_count` 0, `done` 0, `err` 0.
- Write port is registered:
  - A handshake in cycle N gives `imem_we` = 1 with address and data in cycle N+1.
  - A PAD cycle N writes in N+1.
  - `imem_we` is 1 for exactly one cycle per word, and 0 otherwise.
- Handshake and `finish` in the same cycle:
  - The request is written (N+1).
  - PAD begins; its first write lands at N+2 at the next address.
- Accepting the final address (DEPTH-1): DONE from N+1, so `req_ready` is 0 at N+1.
- Back-to-back handshakes give one write per cycle with no bubbles.
- Reset mid-session: state returns to IDLE next cycle. Any pending write is squashed, with no `imem_we` after the reset cycle. `done` stays 0.

## Configuration
- `ENC_ONEHOT_CHECK_EN` defined:
  - A request whose {`req_add`, `req_li`, `req_bne`} is not exactly one-hot is still accepted.
  - It is written as 8'h40 and counted in `inst_count`.
  - `err` is set the cycle after and stays set until `rst` or `start`.
- `ENC_ONEHOT_CHECK_EN` undefined:
  - Priority encode add > li > bne; no flag set gives 8'h40.
  - `err` is tied to 0.

## Test plan
- Reset, `start`, then add(a=1,b=2,c=3), li(a=2,imm=4'hA), bne(a=1,off=4'hE), then `finish` -> addr0=8'h1B, addr1=8'hAA, addr2=8'hDE, addr3..15=8'h40; `inst_count`=3; `done` high 16 write cycles after `start`.
- 16 back-to-back adds with `req_valid` held -> 16 consecutive `imem_we` cycles at addr 0..15; `req_ready` low from the cycle after the 16th handshake; `done`=1; `finish` afterward is ignored.
- Handshake and `finish` in the same cycle at addr 5 -> addr5 holds the request word; PAD writes start at addr6 two cycles after; no address is skipped or written twice.
- `req_add`=`req_li`=1 with the macro defined -> 8'h40 written, `err`=1 until the next `start`; with the macro undefined -> add encoding, `err`=0.
- `rst` asserted during PAD at addr 9 -> no `imem_we` after the reset cycle; all outputs at reset values; a subsequent `start` restarts at addr 0.
